// File: rtl/median_pkg.sv
// Shared definitions for the 3x3 median filter controller.
//   state_t       : controller FSM encoding (IDLE/FETCH/DRAIN/DONE)
//   WIN_DIM/SIZE  : 3x3 window geometry (9 taps, i0..i8 row-major)
//   RESULT_LAT    : cycles from a window's last fetch slot to out_valid
//   MEDIAN_STAGES : register stages inside median_9
//   win_t         : packed 9-entry pixel window
//   min2/max2/med3: byte compare helpers used by median_9
package median_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int WIN_DIM       = 3;
  localparam int WIN_SIZE      = 9;
  localparam int RESULT_LAT    = 4;
  localparam int MEDIAN_STAGES = 2;

  typedef logic [WIN_SIZE-1:0][7:0] win_t;

  function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

endpackage

// File: rtl/median_9.sv
// median_9: two-stage pipelined median of nine bytes.
//   Stage 1 sorts each 3-entry row into low/mid/high.
//   Stage 2 takes med3(max of lows, med of mids, min of highs), which is
//   the median of all nine values.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   win   : nine input bytes (i0..i8)
//   med   : registered median, valid two cycles after win
module median_9
  import median_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  win_t       win,
  output logic [7:0] med
);

  logic [7:0] row_lo  [WIN_DIM];
  logic [7:0] row_mid [WIN_DIM];
  logic [7:0] row_hi  [WIN_DIM];

  logic [7:0] lo_reg  [WIN_DIM];
  logic [7:0] mid_reg [WIN_DIM];
  logic [7:0] hi_reg  [WIN_DIM];

  genvar gi;
  generate
    for (gi = 0; gi < WIN_DIM; gi++) begin : g_row
      assign row_lo[gi]  = min2(min2(win[gi*3], win[gi*3+1]), win[gi*3+2]);
      assign row_mid[gi] = med3(win[gi*3], win[gi*3+1], win[gi*3+2]);
      assign row_hi[gi]  = max2(max2(win[gi*3], win[gi*3+1]), win[gi*3+2]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        lo_reg[r]  <= '0;
        mid_reg[r] <= '0;
        hi_reg[r]  <= '0;
      end
      med <= '0;
    end else begin
      for (int r = 0; r < WIN_DIM; r++) begin
        lo_reg[r]  <= row_lo[r];
        mid_reg[r] <= row_mid[r];
        hi_reg[r]  <= row_hi[r];
      end
      med <= med3(max2(max2(lo_reg[0], lo_reg[1]), lo_reg[2]),
                  med3(mid_reg[0], mid_reg[1], mid_reg[2]),
                  min2(min2(hi_reg[0], hi_reg[1]), hi_reg[2]));
    end
  end

endmodule

// File: rtl/median_ctrl.sv
// median_ctrl: streams an IMG_W x IMG_H image from SRAM through a 3x3
// zero-padded median filter, producing one result per pixel in raster order.
// Optional build macro: MEDIAN_COL_REUSE_EN -- for x>0 only the new right
// column (3 reads) is fetched and the window is shifted left; otherwise all
// nine taps are fetched for every pixel. Results are identical either way.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle frame request (ignored unless idle)
//   busy, done          : frame in progress / one-cycle completion pulse
//   mem_ren, mem_addr   : SRAM read request, row-major address (0 when idle)
//   mem_rdata           : SRAM data, one cycle after mem_ren
//   out_valid           : one pulse per output pixel
//   out_data, out_addr  : median value and its raster address
module median_ctrl
  import median_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] out_addr
);

`ifdef MEDIAN_COL_REUSE_EN
  localparam bit COL_REUSE = 1'b1;
`else
  localparam bit COL_REUSE = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] Y_MAX = ADDR_W'(IMG_H - 1);

  // ---------------------------------------------------------------- FSM
  state_t state_reg, state_next;
  logic   fetching;
  logic   frame_last;
  logic   out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (start) state_next = ST_FETCH;
      ST_FETCH: if (frame_last) state_next = ST_DRAIN;
      ST_DRAIN: if (out_valid && out_last) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
    done     = (state_reg == ST_DONE);
    fetching = (state_reg == ST_FETCH);
  end

  // ------------------------------------------------------ fetch counters
  // (x,y) is the output pixel, (r,c) the window tap being fetched this slot.
  logic [ADDR_W-1:0] x_reg, x_next, y_reg, y_next, pix_reg, pix_next;
  logic [1:0]        r_reg, r_next, c_reg, c_next;
  logic              win_last;
  logic              reuse_win;
  logic              slot_shift;
  logic [3:0]        slot_idx;

  always_comb begin
    win_last   = (r_reg == 2'd2) && (c_reg == 2'd2);
    reuse_win  = COL_REUSE && (x_reg != '0);
    // first slot of a reuse window: shift old columns left as its data lands
    slot_shift = reuse_win && (r_reg == 2'd0);
    frame_last = fetching && win_last && (x_reg == X_MAX) && (y_reg == Y_MAX);
    slot_idx   = 4'(r_reg) * 4'd3 + 4'(c_reg);
  end

  always_comb begin
    x_next   = x_reg;
    y_next   = y_reg;
    pix_next = pix_reg;
    r_next   = r_reg;
    c_next   = c_reg;
    if (state_reg == ST_IDLE && start) begin
      x_next   = '0;
      y_next   = '0;
      pix_next = '0;
      r_next   = '0;
      c_next   = '0;
    end else if (fetching) begin
      if (win_last) begin
        r_next   = '0;
        pix_next = frame_last ? '0 : pix_reg + 1'b1;
        if (x_reg == X_MAX) begin
          x_next = '0;
          y_next = (y_reg == Y_MAX) ? '0 : y_reg + 1'b1;
        end else begin
          x_next = x_reg + 1'b1;
        end
        // next window starts on its right column when it can reuse columns
        c_next = (COL_REUSE && (x_reg != X_MAX)) ? 2'd2 : 2'd0;
      end else if (reuse_win) begin
        r_next = r_reg + 2'd1;
      end else if (c_reg == 2'd2) begin
        c_next = '0;
        r_next = r_reg + 2'd1;
      end else begin
        c_next = c_reg + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg   <= '0;
      y_reg   <= '0;
      pix_reg <= '0;
      r_reg   <= '0;
      c_reg   <= '0;
    end else begin
      x_reg   <= x_next;
      y_reg   <= y_next;
      pix_reg <= pix_next;
      r_reg   <= r_next;
      c_reg   <= c_next;
    end
  end

  // ---------------------------------------------------- SRAM request
  int   nx;
  int   ny;
  logic in_img;

  always_comb begin
    nx       = int'(x_reg) + int'(c_reg) - 1;
    ny       = int'(y_reg) + int'(r_reg) - 1;
    in_img   = fetching && (nx >= 0) && (nx < IMG_W) && (ny >= 0) && (ny < IMG_H);
    mem_ren  = in_img;
    mem_addr = in_img ? ADDR_W'(ny * IMG_W + nx) : '0;
  end

  // ----------------------------------------- load stage (data returns)
  logic              ld_valid_reg, ld_pad_reg, ld_shift_reg, ld_last_reg, ld_plast_reg;
  logic [3:0]        ld_idx_reg;
  logic [ADDR_W-1:0] ld_addr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_valid_reg <= 1'b0;
      ld_pad_reg   <= 1'b0;
      ld_shift_reg <= 1'b0;
      ld_last_reg  <= 1'b0;
      ld_plast_reg <= 1'b0;
      ld_idx_reg   <= '0;
      ld_addr_reg  <= '0;
    end else begin
      ld_valid_reg <= fetching;
      ld_pad_reg   <= !in_img;
      ld_shift_reg <= fetching && slot_shift;
      ld_last_reg  <= fetching && win_last;
      ld_plast_reg <= frame_last;
      ld_idx_reg   <= slot_idx;
      ld_addr_reg  <= pix_reg;
    end
  end

  // ------------------------------------------- window and snapshot
  win_t              win_reg, win_next;
  win_t              snap_reg;
  logic              snap_valid_reg, snap_last_reg;
  logic [ADDR_W-1:0] snap_addr_reg;
  logic [7:0]        load_data;

  always_comb begin
    load_data = ld_pad_reg ? 8'd0 : mem_rdata;
    win_next  = win_reg;
    if (ld_valid_reg) begin
      if (ld_shift_reg) begin
        for (int r = 0; r < WIN_DIM; r++) begin
          win_next[r*3]   = win_reg[r*3+1];
          win_next[r*3+1] = win_reg[r*3+2];
        end
      end
      win_next[ld_idx_reg] = load_data;
    end
  end

  // The snapshot takes win_next so the final tap is forwarded in the same
  // cycle it arrives; the next window may then overwrite win_reg freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_reg        <= '0;
      snap_reg       <= '0;
      snap_valid_reg <= 1'b0;
      snap_last_reg  <= 1'b0;
      snap_addr_reg  <= '0;
    end else begin
      win_reg        <= win_next;
      snap_valid_reg <= ld_valid_reg && ld_last_reg;
      if (ld_valid_reg && ld_last_reg) begin
        snap_reg      <= win_next;
        snap_last_reg <= ld_plast_reg;
        snap_addr_reg <= ld_addr_reg;
      end
    end
  end

  // ------------------------------------ median and matching delay line
  median_9 u_median (
    .clk   (clk),
    .rst_n (rst_n),
    .win   (snap_reg),
    .med   (out_data)
  );

  logic [MEDIAN_STAGES-1:0]             v_pipe;
  logic [MEDIAN_STAGES-1:0]             l_pipe;
  logic [MEDIAN_STAGES-1:0][ADDR_W-1:0] a_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe <= '0;
      l_pipe <= '0;
      a_pipe <= '0;
    end else begin
      v_pipe <= {v_pipe[MEDIAN_STAGES-2:0], snap_valid_reg};
      l_pipe <= {l_pipe[MEDIAN_STAGES-2:0], snap_valid_reg && snap_last_reg};
      a_pipe <= {a_pipe[MEDIAN_STAGES-2:0], snap_addr_reg};
    end
  end

  assign out_valid = v_pipe[MEDIAN_STAGES-1];
  assign out_last  = l_pipe[MEDIAN_STAGES-1];
  assign out_addr  = a_pipe[MEDIAN_STAGES-1];

endmodule

// File: tb/tb_median_ctrl.sv
// Scoreboard bench for median_ctrl (8x8). Expected medians are pushed when
// a frame is started; a negedge monitor pops and compares on every
// out_valid and also evaluates frame-level checks queued by the stimulus.
module tb_median_ctrl;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int AW   = 6;
  localparam int NPIX = W * H;
`ifdef MEDIAN_COL_REUSE_EN
  localparam int FETCH_CYC = 240;
  localparam int EXP_READS = 176;
`else
  localparam int FETCH_CYC = 576;
  localparam int EXP_READS = 484;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, mem_ren, out_valid;
  logic [AW-1:0] mem_addr, out_addr;
  logic [7:0]    mem_rdata, out_data;

  always #5 clk = ~clk;

  median_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_ren   (mem_ren),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr)
  );

  // SRAM model; returns a sentinel when no read was issued
  logic [7:0] img [NPIX];
  always @(posedge clk) mem_rdata <= mem_ren ? img[mem_addr] : 8'hA5;

  typedef struct {logic [AW-1:0] addr; logic [7:0] data;} exp_t;
  typedef struct {string name; int act; int req;} chk_t;
  exp_t exp_q[$];
  chk_t chk_q[$];

  int n_vec = 0, n_err = 0;
  int cyc = 0, n_out = 0, n_done = 0, n_ren = 0, n_busy = 0;
  int bad_bus = 0, last_out_cyc = 0, done_gap = -1;
  int busy_rise = 0, first_out_off = -1;
  bit busy_prev = 1'b0, first_seen = 1'b0;
  int got [NPIX] = '{default: -1};
  exp_t m_e;
  chk_t m_c;

  // ---------------------------------------------------------- monitor
  always @(negedge clk) begin
    cyc++;
    while (chk_q.size() > 0) begin
      m_c = chk_q.pop_front();
      n_vec++;
      if (m_c.act != m_c.req) begin
        n_err++;
        $display("FAIL %s: got %0d, required %0d", m_c.name, m_c.act, m_c.req);
      end
    end
    if (busy && !busy_prev) begin
      busy_rise  = cyc;
      first_seen = 1'b0;
    end
    busy_prev = busy;
    if (busy) n_busy++;
    if (mem_ren) begin
      n_ren++;
      if (int'(mem_addr) >= NPIX) bad_bus++;
    end else if (mem_addr != '0) begin
      bad_bus++;
    end
    if (out_valid) begin
      n_out++;
      last_out_cyc = cyc;
      got[out_addr] = int'(out_data);
      if (!first_seen) begin
        first_out_off = cyc - busy_rise;
        first_seen    = 1'b1;
      end
      $display("out addr=%0d data=%0d", out_addr, out_data);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got addr=%0d data=%0d, required no output", out_addr, out_data);
      end else begin
        m_e = exp_q.pop_front();
        if (out_addr != m_e.addr || out_data != m_e.data) begin
          n_err++;
          $display("FAIL pixel: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   out_addr, out_data, m_e.addr, m_e.data);
        end
      end
    end
    if (done) begin
      n_done++;
      done_gap = cyc - last_out_cyc;
    end
  end

  // ---------------------------------------------------------- helpers
  task automatic push_chk(input string name, input int act, input int req);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.req  = req;
    chk_q.push_back(c);
  endtask

  task automatic load_img(input int kind);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0:       img[i] = 8'd50;
        1:       img[i] = 8'(i);
        default: img[i] = 8'((i * 37 + 11) % 256);
      endcase
    end
  endtask

  function automatic int model_med(input int x, input int y);
    int v[9];
    int k = 0;
    int t;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
          v[k] = int'(img[(y + dy) * W + x + dx]);
        else
          v[k] = 0;
        k++;
      end
    for (int i = 1; i < 9; i++)
      for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
        t = v[j]; v[j] = v[j-1]; v[j-1] = t;
      end
    return v[4];
  endfunction

  task automatic push_model();
    exp_t e;
    for (int p = 0; p < NPIX; p++) begin
      e.addr = AW'(p);
      e.data = 8'(model_med(p % W, p / W));
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input int kind, input bit poke);
    int o0, d0, r0, b0, e0, to;
    load_img(kind);
    push_model();
    o0 = n_out; d0 = n_done; r0 = n_ren; b0 = n_busy; e0 = bad_bus;
    pulse_start();
    if (poke) begin
      repeat (100) @(negedge clk);
      pulse_start();
    end
    to = 0;
    while (n_done == d0 && to < 3000) begin
      @(negedge clk);
      to++;
    end
    repeat (3) @(negedge clk);
    push_chk("out_count",         n_out - o0,  NPIX);
    push_chk("done_count",        n_done - d0, 1);
    push_chk("busy_cycles",       n_busy - b0, FETCH_CYC + 4);
    push_chk("mem_reads",         n_ren - r0,  EXP_READS);
    push_chk("bus_violations",    bad_bus - e0, 0);
    push_chk("first_out_latency", first_out_off, 12);
    push_chk("done_after_last",   done_gap, 1);
    push_chk("leftover_expected", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // --------------------------------------------------------- stimulus
  initial begin
    int o0, to;
    rst_n = 1'b0;
    start = 1'b0;
    #23;
    push_chk("rst_busy",      int'(busy), 0);
    push_chk("rst_done",      int'(done), 0);
    push_chk("rst_mem_ren",   int'(mem_ren), 0);
    push_chk("rst_mem_addr",  int'(mem_addr), 0);
    push_chk("rst_out_valid", int'(out_valid), 0);
    push_chk("rst_out_data",  int'(out_data), 0);
    push_chk("rst_out_addr",  int'(out_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // constant image: corners see five zero pads
    run_frame(0, 1'b0);
    push_chk("const_corner00", got[0],  0);
    push_chk("const_corner70", got[7],  0);
    push_chk("const_corner07", got[56], 0);
    push_chk("const_corner77", got[63], 0);
    push_chk("const_edge10",   got[1],  50);
    push_chk("const_inner11",  got[9],  50);

    // ramp p = y*8+x
    run_frame(1, 1'b0);
    push_chk("ramp_33", got[27], 27);
    push_chk("ramp_00", got[0],  0);
    push_chk("ramp_03", got[24], 17);

    // start pulsed while busy must be ignored
    run_frame(2, 1'b1);

    // reset in the middle of a frame
    load_img(1);
    push_model();
    o0 = n_out;
    pulse_start();
    to = 0;
    while (n_out - o0 < 20 && to < 2000) begin
      @(negedge clk);
      to++;
    end
    push_chk("reached_pixel20", (n_out - o0 >= 20) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    push_chk("mid_rst_busy",      int'(busy), 0);
    push_chk("mid_rst_mem_ren",   int'(mem_ren), 0);
    push_chk("mid_rst_mem_addr",  int'(mem_addr), 0);
    push_chk("mid_rst_out_valid", int'(out_valid), 0);
    push_chk("mid_rst_out_data",  int'(out_data), 0);
    push_chk("mid_rst_out_addr",  int'(out_addr), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    o0 = n_out;
    repeat (60) @(negedge clk);
    push_chk("no_out_after_reset", n_out - o0, 0);
    push_chk("idle_after_reset",   int'(busy), 0);

    // full frame after recovery
    run_frame(1, 1'b0);
    push_chk("post_rst_ramp_33", got[27], 27);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/median_ctrl.md
MEDIAN_CTRL -- requirements
Module: median_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 8, meaning image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 8, meaning image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 6, meaning pixel address width; IMG_W*IMG_H SHALL be <= 2**ADDR_W.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, single-cycle request to filter the whole image.
REQ-007 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking frame completion.
REQ-009 SHALL have port mem_ren, output, 1, image SRAM read enable.
REQ-010 SHALL have port mem_addr, output, ADDR_W, SRAM read address, row-major (y*IMG_W+x).
REQ-011 SHALL have port mem_rdata, input, 8, SRAM data, valid exactly 1 cycle after mem_ren.
REQ-012 SHALL have port out_valid, output, 1, result strobe.
REQ-013 SHALL have port out_data, output, 8, 3x3 median of the current pixel.
REQ-014 SHALL have port out_addr, output, ADDR_W, raster address of out_data.

Function
REQ-015 SHALL implement FSM IDLE -> FETCH (on start) -> DRAIN (after the last fetch of the last pixel) -> DONE (after the last out_valid) -> IDLE (next cycle).
REQ-016 SHALL assert busy in FETCH and DRAIN, and done only in DONE.
REQ-017 SHALL ignore start when not in IDLE.
REQ-018 SHALL process output pixels in raster order, x fastest, (0,0) to (IMG_W-1,IMG_H-1).
REQ-019 SHALL fetch each 3x3 window in order dy=-1..1, dx=-1..1, mapping to median inputs i0..i8; one fetch slot per cycle, with no gap between windows.
REQ-020 SHALL, for a window position outside the image, hold mem_ren=0 in that slot and load 8'd0 (zero padding).
REQ-021 SHALL copy the complete 9-entry window into a snapshot register feeding median_9, so fetching of the next window overwrites the window buffer without hazard.
REQ-022 SHALL assert out_valid, registered, exactly 4 cycles after the cycle in which the window's last fetch slot occurred, with out_data/out_addr registered alongside it.
REQ-023 SHALL drive out_valid for exactly one cycle per pixel, IMG_W*IMG_H pulses per frame.
REQ-024 SHALL drive mem_addr and mem_ren to 0 whenever no read is issued.
REQ-025 SHALL compute x/y counters with wrap: x wraps at IMG_W-1 to 0 and increments y; y=IMG_H-1 with x wrapping ends FETCH.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-frame, asynchronously force IDLE, all counters, window and pipeline registers to 0, and busy, done, mem_ren, mem_addr, out_valid, out_data and out_addr to 0.
REQ-027 SHALL produce no out_valid after reset release until a new start.

Configuration
REQ-028 SHALL, with macro MEDIAN_COL_REUSE_EN defined, fetch all 9 slots for x=0 only; for x>0 it SHALL shift the window left one column and fetch just the new right column (dy=-1..1 into i2,i5,i8) in 3 slots.
REQ-029 SHALL, without MEDIAN_COL_REUSE_EN, use 9 fetch slots for every pixel; output values SHALL be identical in both builds.

Structure
REQ-030 SHALL place FSM state encoding, the window size (9) and the 4-cycle result latency constant in shared package median_pkg.
REQ-031 SHALL instantiate the existing median_9 (2 register stages) as its single sub-module; the controller SHALL NOT re-implement sorting.

Verification
REQ-032 SHALL test a constant image of 8'd50 at 8x8 -> 4 corner outputs 0, all other 60 outputs 50, and exactly 64 out_valid pulses.
REQ-033 SHALL test a pixel ramp p=y*8+x -> interior (3,3) outputs 27; the (0,0) window {0,0,0,0,0,1,0,8,9} outputs 0.
REQ-034 SHALL test the cycle count for 8x8 -> 576 fetch cycles without the macro and 240 with MEDIAN_COL_REUSE_EN; done is asserted 1 cycle after the last out_valid.
REQ-035 SHALL test start pulsed during busy -> ignored, with exactly 64 outputs and one done.
REQ-036 SHALL test rst_n low at pixel 20 -> all outputs 0 immediately; no out_valid until start; a new start yields a full, correct frame.
REQ-037 SHALL test padding reads -> mem_ren never asserted for an out-of-image address, and every mem_addr < 64.
